demux8bit2way_buf: RTL
======================

// Module: demux8bit2way_buf
// PURPOSE
//  Registered 1-to-2 demultiplexer: the inverse of the 2-way byte mux. Routes one
//  input byte stream to one of two consumers, either timer mode A (out1) or timer
//  mode B (out2), selected per transfer by sel. Each output has a one-entry holding
//  register with a valid/ready handshake. Sits between the keypad/setting path and
//  the two timer-mode cores.
// PARAMETERS
//  WIDTH   8   data width of in_data, out1_data and out2_data
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_data    in   WIDTH  byte to route
//  in_valid   in   1      in_data and sel are valid this cycle
//  sel        in   1      0 -> out1, 1 -> out2; sampled only on accept
//  in_ready   out  1      block can accept this cycle
//  out1_data  out  WIDTH  held byte for mode A
//  out1_valid out  1      out1 holding register full
//  out1_ready in   1      mode A consumes out1_data this cycle
//  out2_data  out  WIDTH  held byte for mode B
//  out2_valid out  1      out2 holding register full
//  out2_ready in   1      mode B consumes out2_data this cycle
// BEHAVIOUR
//  - Reset (sync, high): out1_valid = out2_valid = 0, out1_data = out2_data = 0,
//    in_ready = 0 while reset is high. Reset mid-transfer discards held bytes.
//  - Per-output FSM, states EMPTY and FULL (outN_valid = FULL):
//    EMPTY -> FULL on accept with sel targeting N;
//    FULL -> EMPTY on outN_ready with no new accept to N;
//    FULL -> FULL with the new byte loaded on outN_ready plus an accept to N.
//  - in_ready = !reset && (sel ? (!out2_valid || out2_ready)
//                              : (!out1_valid || out1_ready)).
//    Combinational from sel and the ready inputs of the targeted output only.
//  - Accept = in_valid && in_ready. On accept the target outN_data <= in_data
//    and outN_valid <= 1. Latency is exactly 1 cycle from accept to outN_valid.
//  - Throughput: 1 byte/cycle to one output while its consumer holds ready high.
//  - A full non-target output never blocks: out2 held while sel=0 still allows
//    out1 traffic.
//  - outN_data is stable while outN_valid && !outN_ready. It holds its last
//    value when EMPTY and is not cleared on drain.
//  - outN_ready while EMPTY has no effect.
//  - in_valid && !in_ready: no state change. The source must hold in_data and
//    sel until accepted.
//  - Only one output can load per cycle. Both outputs may drain in the same cycle.
// CONFIGURATION
//  DEMUX_COUNT_EN defined: adds outputs cnt1[7:0] and cnt2[7:0], which count
//    accepted transfers routed to out1 and out2. They reset to 0 and wrap
//    from 255 to 0. The count updates the cycle after accept.
//  DEMUX_COUNT_EN undefined: no counter ports and no counter logic. All other
//    behaviour is identical.
// TESTING
//  1 reset=1 for 2 cycles, in_valid=1 -> in_ready=0, both valids 0, data 0x00.
//  2 sel=0, in_data=0x3C, out1_ready=0 -> out1_valid=1 and out1_data=0x3C next
//    cycle. A second byte with sel=0 sees in_ready=0. sel=1 with 0x5A is
//    accepted and lands on out2.
//  3 Stream 0x01..0x10 with sel=0 and out1_ready=1 -> one byte/cycle, in order,
//    latency 1, no drops, out2_valid stays 0.
//  4 out1 FULL(0x77) with out1_ready=1 in the same cycle as accept 0x88 sel=0
//    -> out1_valid stays 1, out1_data=0x88 next cycle.
//  5 Reset asserted while both outputs are FULL -> both valids 0 next cycle.
//    Held bytes are never presented after reset.
//  6 [DEMUX_COUNT_EN] 256 accepts to out1 and 3 to out2 -> cnt1=0 (wrapped),
//    cnt2=3.

Source files
------------

// File: rtl/demux8bit2way_buf_if.sv
// rtl/demux8bit2way_buf_if.sv - handshake bus bundle for the 1-to-2 byte demultiplexer
interface demux8bit2way_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;

    // Producer of the input stream and consumer of both outputs
    modport master (
        output in_data, in_valid, sel, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );

    // The demultiplexer itself
    modport slave (
        input  in_data, in_valid, sel, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/demux8bit2way_buf.sv
// rtl/demux8bit2way_buf.sv - registered 1-to-2 byte demux with per-output holding register; optional DEMUX_COUNT_EN transfer counters
module demux8bit2way_buf #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    demux8bit2way_buf_if.slave   bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]           cnt1,
    output logic [7:0]           cnt2
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state1_q, state1_d;
    state_t           state2_q, state2_d;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] data2_q;
    logic             in_ready;
    logic             load1;
    logic             load2;

    // Readiness depends only on the targeted output, then per-output next state
    always_comb begin
        in_ready = 1'b0;
        load1    = 1'b0;
        load2    = 1'b0;
        state1_d = state1_q;
        state2_d = state2_q;

        if (!reset) begin
            if (bus.sel) begin
                in_ready = (state2_q == EMPTY) || bus.out2_ready;
            end else begin
                in_ready = (state1_q == EMPTY) || bus.out1_ready;
            end
        end

        load1 = bus.in_valid && in_ready && !bus.sel;
        load2 = bus.in_valid && in_ready && bus.sel;

        case (state1_q)
            EMPTY:   if (load1) state1_d = FULL;
            FULL:    if (bus.out1_ready && !load1) state1_d = EMPTY;
            default: state1_d = EMPTY;
        endcase

        case (state2_q)
            EMPTY:   if (load2) state2_d = FULL;
            FULL:    if (bus.out2_ready && !load2) state2_d = EMPTY;
            default: state2_d = EMPTY;
        endcase
    end

    // State registers; held data is only overwritten by a load, never on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            state1_q <= EMPTY;
            state2_q <= EMPTY;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state1_q <= state1_d;
            state2_q <= state2_d;
            if (load1) data1_q <= bus.in_data;
            if (load2) data2_q <= bus.in_data;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Free-running wrap-around counts of transfers routed to each output
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt1 <= 8'd0;
            cnt2 <= 8'd0;
        end else begin
            if (load1) cnt1 <= cnt1 + 8'd1;
            if (load2) cnt2 <= cnt2 + 8'd1;
        end
    end
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out1_valid = (state1_q == FULL);
    assign bus.out2_valid = (state2_q == FULL);
    assign bus.out1_data  = data1_q;
    assign bus.out2_data  = data2_q;
endmodule
